// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the register-array write-port controllers:
// FSM states, requester identifiers and an address range helper.
package array_ctrl_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    INIT = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    REQ0     = 2'd0,
    REQ1     = 2'd1,
    CPU      = 2'd2,
    REQ_NONE = 2'd3
  } req_id_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/array131_wrsched_rr2_arb.sv
// Two-way round-robin arbiter; grants only while i_adv is high and then
// hands priority to the requester that was not just served.
module rr2_arb (
  input  logic       clk,
  input  logic       rst_,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic r_ptr;  // 0: requester 0 wins a tie, 1: requester 1 wins a tie

  always_comb begin
    o_gnt = 2'b00;
    if (i_adv) begin
      if (i_req == 2'b11) begin
        o_gnt = r_ptr ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_ptr <= 1'b0;
    end else if (o_gnt != 2'b00) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/array131_wrsched.sv
// Write-port scheduler: shares the array write port between two datapath
// requesters and the CPU, runs the fill sweep and drives parity control.
module array131_wrsched
  import array_ctrl_pkg::*;
#(
  parameter int ADDRBIT  = 9,
  parameter int DEPTH    = 512,
  parameter int WIDTH    = 32,
  parameter int AUTOINIT = 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               req0,
  input  logic               req1,
  input  logic [ADDRBIT-1:0] wa0,
  input  logic [ADDRBIT-1:0] wa1,
  input  logic [WIDTH-1:0]   di0,
  input  logic [WIDTH-1:0]   di1,
  output logic               gnt0,
  output logic               gnt1,
  input  logic               cpu_req,
  input  logic [ADDRBIT-1:0] cpu_wa,
  input  logic [WIDTH-1:0]   cpu_di,
  output logic               cpu_gnt,
  input  logic               init_start,
  input  logic [WIDTH-1:0]   init_val,
  output logic               init_busy,
  output logic               init_done,
  input  logic               par_clr_req,
  input  logic               cpu_pardis,
  input  logic               err_clr,
  output logic               we,
  output logic [ADDRBIT-1:0] wa,
  output logic [WIDTH-1:0]   di,
  output logic [1:0]         par_ctrl,
  output logic               addr_err
);

  localparam logic [ADDRBIT-1:0] CNT_LAST = ADDRBIT'(DEPTH - 1);

  wr_state_e          r_state;
  logic [ADDRBIT-1:0] r_cnt;
  logic               r_cpu_block;
  logic               r_we;
  logic [ADDRBIT-1:0] r_wa;
  logic [WIDTH-1:0]   r_di;
  logic               r_init_done;
  logic               r_addr_err;
  logic [1:0]         r_par_ctrl;

  logic               w_arb_open;
  logic               w_cpu_win;
  logic [1:0]         w_dp_gnt;
  req_id_e            w_sel;
  logic [ADDRBIT-1:0] w_sel_wa;
  logic [WIDTH-1:0]   w_sel_di;
  logic               w_sel_ok;

  // The cycle that starts a sweep issues no grants at all.
  assign w_arb_open = (r_state == ARB) && !init_start;
  assign w_cpu_win  = w_arb_open && cpu_req && !r_cpu_block;

  rr2_arb u_rr (
    .clk   (clk),
    .rst_  (rst_),
    .i_req ({req1, req0}),
    .i_adv (w_arb_open && !w_cpu_win),
    .o_gnt (w_dp_gnt)
  );

  always_comb begin
    w_sel    = REQ_NONE;
    w_sel_wa = wa0;
    w_sel_di = di0;
    if (w_cpu_win) begin
      w_sel    = CPU;
      w_sel_wa = cpu_wa;
      w_sel_di = cpu_di;
    end else if (w_dp_gnt[1]) begin
      w_sel    = REQ1;
      w_sel_wa = wa1;
      w_sel_di = di1;
    end else if (w_dp_gnt[0]) begin
      w_sel    = REQ0;
    end
  end

  assign w_sel_ok = addr_in_range(32'(w_sel_wa), DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state     <= (AUTOINIT != 0) ? INIT : ARB;
      r_cnt       <= '0;
      r_cpu_block <= 1'b0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_di        <= '0;
      r_init_done <= 1'b0;
      r_addr_err  <= 1'b0;
      r_par_ctrl  <= 2'b00;
    end else begin
      r_par_ctrl  <= {cpu_pardis, par_clr_req};
      r_cpu_block <= w_cpu_win && (req0 || req1);
      r_init_done <= 1'b0;
      r_we        <= 1'b0;

      case (r_state)
        ARB: begin
          if (init_start) begin
            r_state <= INIT;
            r_cnt   <= '0;
          end else if (w_sel != REQ_NONE && w_sel_ok) begin
            r_we <= 1'b1;
            r_wa <= w_sel_wa;
            r_di <= w_sel_di;
          end
        end
        INIT: begin
          r_we <= 1'b1;
          r_wa <= r_cnt;
          r_di <= init_val;
          if (r_cnt == CNT_LAST) begin
            r_state     <= ARB;
            r_init_done <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ARB;
      endcase

      // A dropped write outranks a simultaneous clear.
      if (w_sel != REQ_NONE && !w_sel_ok) begin
        r_addr_err <= 1'b1;
      end else if (err_clr) begin
        r_addr_err <= 1'b0;
      end
    end
  end

  assign gnt0      = w_dp_gnt[0];
  assign gnt1      = w_dp_gnt[1];
  assign cpu_gnt   = w_cpu_win;
  assign init_busy = (r_state == INIT);
  assign init_done = r_init_done;
  assign we        = r_we;
  assign wa        = r_wa;
  assign di        = r_di;
  assign par_ctrl  = r_par_ctrl;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_array131_wrsched.sv
// Bench for array131_wrsched: a 512-entry auto-init instance for sweeps and
// arbitration, plus a 400-entry instance for out-of-range address handling.
module tb_array131_wrsched;

  localparam int AB = 9;
  localparam int W  = 32;
  localparam int DA = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_;
  logic          req0, req1, cpu_req, init_start, par_clr_req, cpu_pardis, err_clr;
  logic [AB-1:0] wa0, wa1, cpu_wa;
  logic [W-1:0]  di0, di1, cpu_di, init_val;
  logic          gnt0, gnt1, cpu_gnt, init_busy, init_done, we, addr_err;
  logic [AB-1:0] wa;
  logic [W-1:0]  di;
  logic [1:0]    par_ctrl;

  logic          b_cpu_req, b_err_clr;
  logic [AB-1:0] b_cpu_wa;
  logic [W-1:0]  b_cpu_di;
  logic          b_gnt0, b_gnt1, b_cpu_gnt, b_init_busy, b_init_done, b_we, b_addr_err;
  logic [AB-1:0] b_wa;
  logic [W-1:0]  b_di;
  logic [1:0]    b_par_ctrl;

  array131_wrsched #(.ADDRBIT(AB), .DEPTH(DA), .WIDTH(W), .AUTOINIT(1)) dut (
    .clk(clk), .rst_(rst_),
    .req0(req0), .req1(req1), .wa0(wa0), .wa1(wa1), .di0(di0), .di1(di1),
    .gnt0(gnt0), .gnt1(gnt1),
    .cpu_req(cpu_req), .cpu_wa(cpu_wa), .cpu_di(cpu_di), .cpu_gnt(cpu_gnt),
    .init_start(init_start), .init_val(init_val), .init_busy(init_busy), .init_done(init_done),
    .par_clr_req(par_clr_req), .cpu_pardis(cpu_pardis), .err_clr(err_clr),
    .we(we), .wa(wa), .di(di), .par_ctrl(par_ctrl), .addr_err(addr_err)
  );

  array131_wrsched #(.ADDRBIT(AB), .DEPTH(400), .WIDTH(W), .AUTOINIT(0)) dut_b (
    .clk(clk), .rst_(rst_),
    .req0(1'b0), .req1(1'b0), .wa0('0), .wa1('0), .di0('0), .di1('0),
    .gnt0(b_gnt0), .gnt1(b_gnt1),
    .cpu_req(b_cpu_req), .cpu_wa(b_cpu_wa), .cpu_di(b_cpu_di), .cpu_gnt(b_cpu_gnt),
    .init_start(1'b0), .init_val('0), .init_busy(b_init_busy), .init_done(b_init_done),
    .par_clr_req(1'b0), .cpu_pardis(1'b0), .err_clr(b_err_clr),
    .we(b_we), .wa(b_wa), .di(b_di), .par_ctrl(b_par_ctrl), .addr_err(b_addr_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit            m_blk, m_nxt, e_we, e_pc, e_pd;
  logic [AB-1:0] e_wa;
  logic [W-1:0]  e_di, exp_iv, bdat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check(input bit rnd);
    for (int i = 0; i < DA; i++) begin
      tick();
      chk("sweep_we", 64'(we), 64'd1);
      chk("sweep_wa", 64'(wa), 64'(i));
      chk("sweep_di", 64'(di), 64'(exp_iv));
      chk("sweep_busy", 64'(init_busy), 64'(i < DA - 1));
      chk("sweep_done", 64'(init_done), 64'(i == DA - 1));
      if (rnd) init_val = $urandom;
      exp_iv = init_val;
      if (i == DA - 1) req0 = 1'b0;
      #1;
      if (i < DA - 1) chk("sweep_no_gnt", 64'({gnt0, gnt1, cpu_gnt}), 64'd0);
    end
  endtask

  task automatic run_cycles(input int n, input int pr0, input int pr1, input int prc);
    int g;
    bit d0, d1, dc;
    d0 = 0; d1 = 0; dc = 0;
    for (int c = 0; c <= n; c++) begin
      tick();
      if (d0) req0 = 1'b0;
      if (d1) req1 = 1'b0;
      if (dc) cpu_req = 1'b0;
      chk("we", 64'(we), 64'(e_we));
      if (e_we) begin
        chk("wa", 64'(wa), 64'(e_wa));
        chk("di", 64'(di), 64'(e_di));
      end
      chk("par_ctrl", 64'(par_ctrl), 64'({e_pd, e_pc}));
      chk("init_done_idle", 64'(init_done), 64'd0);
      if (c == n) begin
        req0 = 1'b0; req1 = 1'b0; cpu_req = 1'b0;
        par_clr_req = 1'b0; cpu_pardis = 1'b0;
      end else begin
        if (!req0 && $urandom_range(99) < pr0) begin
          req0 = 1'b1; wa0 = AB'($urandom); di0 = $urandom;
        end
        if (!req1 && $urandom_range(99) < pr1) begin
          req1 = 1'b1; wa1 = AB'($urandom); di1 = $urandom;
        end
        if (!cpu_req && $urandom_range(99) < prc) begin
          cpu_req = 1'b1; cpu_wa = AB'($urandom); cpu_di = $urandom;
        end
        par_clr_req = 1'($urandom_range(1));
        cpu_pardis  = 1'($urandom_range(1));
      end
      #1;
      g = -1;
      if (cpu_req && !m_blk) g = 2;
      else if (req0 && req1) g = m_nxt ? 1 : 0;
      else if (req0) g = 0;
      else if (req1) g = 1;
      chk("gnt0", 64'(gnt0), 64'(g == 0));
      chk("gnt1", 64'(gnt1), 64'(g == 1));
      chk("cpu_gnt", 64'(cpu_gnt), 64'(g == 2));
      m_blk = (g == 2) && (req0 || req1);
      if (g == 0) m_nxt = 1'b1;
      if (g == 1) m_nxt = 1'b0;
      e_we = (g >= 0);
      if (g == 0) begin e_wa = wa0; e_di = di0; end
      if (g == 1) begin e_wa = wa1; e_di = di1; end
      if (g == 2) begin e_wa = cpu_wa; e_di = cpu_di; end
      d0 = (g == 0); d1 = (g == 1); dc = (g == 2);
      e_pc = par_clr_req; e_pd = cpu_pardis;
    end
  endtask

  initial begin
    rst_ = 1'b0;
    req0 = 1'b1; req1 = 1'b0; cpu_req = 1'b0; init_start = 1'b0;
    par_clr_req = 1'b0; cpu_pardis = 1'b0; err_clr = 1'b0;
    wa0 = '0; wa1 = '0; cpu_wa = '0; di0 = '0; di1 = '0; cpu_di = '0;
    init_val = 32'hA5A5A5A5;
    b_cpu_req = 1'b0; b_err_clr = 1'b0; b_cpu_wa = '0; b_cpu_di = '0;

    // Reset state
    tick();
    tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_addr_err", 64'(addr_err), 64'd0);
    chk("rst_par_ctrl", 64'(par_ctrl), 64'd0);
    chk("rst_busy_auto", 64'(init_busy), 64'd1);
    chk("rst_busy_noauto", 64'(b_init_busy), 64'd0);

    // Auto-init sweep; req0 is held throughout and must wait
    rst_ = 1'b1;
    #1;
    chk("first_init_no_gnt", 64'(gnt0), 64'd0);
    exp_iv = init_val;
    sweep_check(1'b0);
    m_nxt = 1'b0; m_blk = 1'b0; e_we = 1'b0; e_pc = 1'b0; e_pd = 1'b0;

    // Arbitration: both datapath held, CPU with req0 held, then random mix
    run_cycles(40, 100, 100, 0);
    run_cycles(40, 100, 0, 100);
    run_cycles(300, 50, 50, 40);

    // Directed parity control
    par_clr_req = 1'b1; cpu_pardis = 1'b1;
    tick();
    chk("par_clr_pulse", 64'(par_ctrl), 64'b11);
    par_clr_req = 1'b0;
    tick();
    chk("par_clr_once", 64'(par_ctrl), 64'b10);
    cpu_pardis = 1'b0;
    tick();
    chk("par_idle", 64'(par_ctrl), 64'b00);

    // Sweep started then aborted by reset at N+100
    req0 = 1'b1; init_start = 1'b1;
    #1;
    chk("start_cycle_no_gnt", 64'(gnt0), 64'd0);
    tick();
    init_start = 1'b0;
    chk("start_busy", 64'(init_busy), 64'd1);
    for (int k = 2; k < 100; k++) begin
      tick();
      chk("abort_busy", 64'(init_busy), 64'd1);
      chk("abort_done", 64'(init_done), 64'd0);
      chk("abort_we", 64'(we), 64'd1);
      chk("abort_wa", 64'(wa), 64'(k - 2));
      #1;
      chk("abort_no_gnt", 64'(gnt0), 64'd0);
    end
    tick();
    rst_ = 1'b0;
    tick();
    chk("abort_rst_we", 64'(we), 64'd0);
    chk("abort_rst_done", 64'(init_done), 64'd0);
    chk("abort_rst_busy", 64'(init_busy), 64'd1);
    tick();
    rst_ = 1'b1;
    init_val = $urandom;
    exp_iv = init_val;
    sweep_check(1'b1);

    // Out-of-range handling on the 400-entry instance
    bdat = $urandom;
    b_cpu_req = 1'b1; b_cpu_wa = 9'd450; b_cpu_di = bdat;
    #1;
    chk("oor_gnt", 64'(b_cpu_gnt), 64'd1);
    tick();
    b_cpu_req = 1'b0;
    chk("oor_we", 64'(b_we), 64'd0);
    chk("oor_err", 64'(b_addr_err), 64'd1);
    tick();
    chk("oor_err_sticky", 64'(b_addr_err), 64'd1);
    b_err_clr = 1'b1;
    tick();
    b_err_clr = 1'b0;
    chk("oor_err_cleared", 64'(b_addr_err), 64'd0);
    b_cpu_req = 1'b1; b_cpu_wa = 9'd399;
    #1;
    chk("edge_gnt", 64'(b_cpu_gnt), 64'd1);
    tick();
    b_cpu_req = 1'b0;
    chk("edge_we", 64'(b_we), 64'd1);
    chk("edge_wa", 64'(b_wa), 64'd399);
    chk("edge_di", 64'(b_di), 64'(bdat));
    chk("edge_err", 64'(b_addr_err), 64'd0);
    b_cpu_req = 1'b1; b_cpu_wa = 9'd400;
    tick();
    b_cpu_req = 1'b0;
    chk("d400_we", 64'(b_we), 64'd0);
    chk("d400_err", 64'(b_addr_err), 64'd1);
    b_cpu_req = 1'b1; b_cpu_wa = 9'd511; b_err_clr = 1'b1;
    tick();
    b_cpu_req = 1'b0; b_err_clr = 1'b0;
    chk("set_beats_clr", 64'(b_addr_err), 64'd1);
    b_err_clr = 1'b1;
    tick();
    b_err_clr = 1'b0;
    chk("final_clr", 64'(b_addr_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/array131_wrsched.md
# array131_wrsched

Write-port scheduler for the three-read/one-write parity-protected register array. It shares the array's single write port among two datapath requesters and a CPU requester, and runs an initialization sweep that fills every entry with a known value so stored parity is consistent. It also drives the array's parity-control bits. It sits directly in front of the array, on the array's write clock.

## Interface
Parameters:
- ADDRBIT, 9, array address width
- DEPTH, 512, number of array entries
- WIDTH, 32, data width
- AUTOINIT, 1, 1 = start an init sweep out of reset

Ports:
- clk  in  1  single clock (the array's write clock)
- rst_  in  1  reset: **one clock; reset is synchronous and active-low**
- req0 / req1  in  1  datapath write requests; held until the matching gnt
- wa0 / wa1  in  ADDRBIT  datapath write addresses
- di0 / di1  in  WIDTH  datapath write data
- gnt0 / gnt1  out  1  combinational grant; the request is consumed in the grant cycle
- cpu_req  in  1  CPU write request; held until cpu_gnt
- cpu_wa  in  ADDRBIT  CPU write address
- cpu_di  in  WIDTH  CPU write data
- cpu_gnt  out  1  combinational CPU grant
- init_start  in  1  pulse; requests an init sweep
- init_val  in  WIDTH  fill value, sampled on every sweep write
- init_busy  out  1  sweep in progress
- init_done  out  1  one-cycle pulse when the sweep completes
- par_clr_req  in  1  pulse; requests a parity-error clear
- cpu_pardis  in  1  disables parity calculation (test mode)
- err_clr  in  1  clears addr_err
- we  out  1  array write enable (registered)
- wa  out  ADDRBIT  array write address (registered)
- di  out  WIDTH  array write data (registered)
- par_ctrl  out  2  [0] parity-error clear pulse; [1] parity disable (both registered)
- addr_err  out  1  sticky flag: a write was dropped because its address was out of range

## Operation
- The FSM has two states:
  - ARB: normal arbitration.
  - INIT: sweep counter cnt runs 0..DEPTH-1.
- Reset values:
  - state = INIT if AUTOINIT, else ARB; cnt = 0.
  - init_busy = AUTOINIT.
  - we, wa, di, par_ctrl, init_done, addr_err = 0.
  - Round-robin pointer = requester 0; cpu_block = 0.
- ARB, grant rules (at most one grant per cycle):
  - CPU has priority when cpu_req=1 and cpu_block=0.
  - cpu_block is set for the cycle after each CPU grant, and only if req0 or req1 is pending. This is the anti-starvation rule.
  - Otherwise req0/req1 are served round-robin. After a grant, the pointer moves to the other requester.
  - Only one datapath request pending: it is granted regardless of the pointer.
- On a grant, the granted wa/di are loaded into the output registers next cycle with we=1.
- Out-of-range address (granted address >= DEPTH):
  - The request is still granted (consumed), but we stays 0 and addr_err is set.
  - addr_err holds until err_clr; if set and err_clr coincide, set wins.
- Sweep entry: init_start in ARB goes to INIT next cycle, with cnt=0. No grants are issued in that transition cycle.
- INIT:
  - Each cycle loads we=1, wa=cnt, di=init_val; cnt increments.
  - At cnt=DEPTH-1 the FSM returns to ARB and init_done pulses.
  - All grants are 0; requests wait.
  - init_start is ignored.
- Reset mid-sweep aborts the sweep. The FSM restarts from cnt=0 if AUTOINIT; otherwise it goes to ARB.
- Parity control:
  - par_ctrl[0] = par_clr_req delayed one cycle.
  - par_ctrl[1] = cpu_pardis delayed one cycle.
- cnt width is ADDRBIT; no wrap occurs because the sweep ends at DEPTH-1.

## Timing
- Grant at cycle N gives we/wa/di valid at N+1. Sustained throughput is one write per cycle.
- init_start at cycle N:
  - init_busy = 1 for cycles N+1..N+DEPTH.
  - Sweep writes are on the array port at N+2..N+DEPTH+1 (addresses 0..DEPTH-1).
  - init_done pulses at N+DEPTH+1.
  - The first grant is possible at N+DEPTH+1.
- AUTOINIT: the first cycle with rst_=1 is INIT with cnt=0, and writes start one cycle later.
- A CPU request competing with a continuously asserted datapath request is granted at worst every second cycle.

## Structure
- Shared package array_ctrl_pkg holds:
  - FSM state encoding (ARB, INIT).
  - Requester ID constants (REQ0, REQ1, CPU).
- Sub-module rr2_arb: two-way round-robin arbiter with request inputs, grant outputs and an advance strobe. It is reusable by other array controllers.

## Test plan
- AUTOINIT=1, DEPTH=512, init_val=32'hA5A5A5A5 → init_busy high for 512 cycles, we=1 on addresses 0..511 in order, then one init_done pulse; no grants during the sweep.
- req0 and req1 held continuously with no CPU → gnt0 and gnt1 alternate every cycle; wa/di match the granted requester one cycle later.
- cpu_req held together with req0 → cpu_gnt and gnt0 alternate, i.e. a CPU grant every second cycle.
- DEPTH=400, cpu_wa=9'd450 → cpu_gnt=1, we stays 0, addr_err=1 until err_clr; err_clr coinciding with a new bad write leaves addr_err=1.
- init_start at N, then rst_ low at N+100 for 2 cycles → sweep restarts at address 0; the old sweep produces no init_done.
- par_clr_req pulse at cycle M → par_ctrl[0]=1 at M+1 only; cpu_pardis=1 → par_ctrl[1]=1 from the next cycle.
